// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame layout, FSM state encoding and timeout cycle computation.
package ps2_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = FRAME_BITS - 3;

   function automatic int to_cyc(input int clk_hz, input int us);
      return clk_hz / 1000000 * us;
   endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// PS/2 line conditioning: 2-flop synchronizers, clock glitch filter,
// falling-edge strobe of the filtered clock and synchronized data.
module ps2_rx_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic sys_clk,
   input  logic sys_res,
   input  logic ps2clk,
   input  logic ps2dat,
   output logic fall,
   output logic dat
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          filt;
   logic [CW-1:0] cnt;

   // Idle bus is high, so everything resets to 1 to avoid a spurious fall.
   always_ff @(posedge sys_clk) begin
      if (sys_res) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt     <= 1'b1;
         cnt      <= '0;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2clk};
         dat_sync <= {dat_sync[0], ps2dat};
         fall     <= 1'b0;
         if (clk_sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= clk_sync[1];
            cnt  <= '0;
            fall <= filt;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign dat = dat_sync[1];

endmodule

// File: rtl/ps2_rx.sv
// Host-side PS/2 keyboard receiver with CPU ready/rd handshake.
// Define PS2_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO.
module ps2_rx
   import ps2_rx_pkg::*;
#(
   parameter int CLK_HZ     = 6000000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 200
`ifdef PS2_RX_FIFO_EN
   ,
   parameter int FIFO_DEPTH = 4
`endif
) (
   input  logic       sys_clk,
   input  logic       sys_res,
   input  logic       ps2clk,
   input  logic       ps2dat,
   input  logic       rd,
   output logic [7:0] data,
   output logic       ready,
   output logic       err_parity,
   output logic       err_frame,
   output logic       overrun
);

   localparam int TO_CYC = to_cyc(CLK_HZ, TIMEOUT_US);
   localparam int TW     = $clog2(TO_CYC + 1);
   localparam int NW     = $clog2(DATA_BITS);

   logic          fall;
   logic          dat;
   state_t        state, state_n;
   logic [NW-1:0] cnt, cnt_n;
   logic [7:0]    sh, sh_n;
   logic          par, par_n;
   logic [TW-1:0] tmo, tmo_n;
   logic          push;
   logic          perr;
   logic          ferr;

   ps2_rx_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .sys_clk (sys_clk),
      .sys_res (sys_res),
      .ps2clk  (ps2clk),
      .ps2dat  (ps2dat),
      .fall    (fall),
      .dat     (dat)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_res) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         sh         <= '0;
         par        <= 1'b0;
         tmo        <= '0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         sh         <= sh_n;
         par        <= par_n;
         tmo        <= tmo_n;
         err_parity <= perr;
         err_frame  <= ferr;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sh_n    = sh;
      par_n   = par;
      push    = 1'b0;
      perr    = 1'b0;
      ferr    = 1'b0;
      tmo_n   = (fall || state == ST_IDLE) ? '0 : tmo + 1'b1;
      if (fall) begin
         unique case (state)
            ST_IDLE: begin
               if (!dat) begin
                  state_n = ST_DATA;
                  cnt_n   = '0;
               end
            end
            ST_DATA: begin
               sh_n = {dat, sh[7:1]};
               if (cnt == NW'(DATA_BITS - 1)) begin
                  state_n = ST_PARITY;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            ST_PARITY: begin
               par_n   = dat;
               state_n = ST_STOP;
            end
            ST_STOP: begin
               state_n = ST_IDLE;
               // Parity fault wins over a bad stop bit.
               if (!(^{sh, par})) begin
                  perr = 1'b1;
               end else if (!dat) begin
                  ferr = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
         endcase
      end else if (state != ST_IDLE && tmo == TW'(TO_CYC - 1)) begin
         state_n = ST_IDLE;
         tmo_n   = '0;
         ferr    = 1'b1;
      end
   end

`ifdef PS2_RX_FIFO_EN

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   count;
   logic          full;
   logic          pop;
   logic          wr;

   assign full = (count == (AW+1)'(FIFO_DEPTH));
   assign pop  = rd && (count != '0);
   assign wr   = push && (!full || pop);

   always_ff @(posedge sys_clk) begin
      if (sys_res) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wp      <= '0;
         rp      <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= push && !wr;
         if (wr) begin
            mem[wp] <= sh;
            wp      <= wp + 1'b1;
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         if (wr && !pop) begin
            count <= count + 1'b1;
         end else if (!wr && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   assign data  = mem[rp];
   assign ready = (count != '0);

`else

   // A byte landing with rd in the same cycle replaces the one being read.
   always_ff @(posedge sys_clk) begin
      if (sys_res) begin
         data    <= '0;
         ready   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (push && (!ready || rd)) begin
            data  <= sh;
            ready <= 1'b1;
         end else begin
            if (push) begin
               overrun <= 1'b1;
            end
            if (rd) begin
               ready <= 1'b0;
            end
         end
      end
   end

`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: behavioural keyboard, 80us PS/2 clock period.
`timescale 1ns/1ps
module tb_ps2_rx;

   localparam int FL = 8;
   localparam int TO = 1200;

   logic       sys_clk = 1'b0;
   logic       sys_res;
   logic       ps2clk;
   logic       ps2dat;
   logic       rd;
   logic [7:0] data;
   logic       ready;
   logic       err_parity;
   logic       err_frame;
   logic       overrun;

   int nvec = 0;
   int nbad = 0;
   int n_par = 0;
   int n_frm = 0;
   int n_ovr = 0;
   int n_wide = 0;
   logic pp = 0, pf = 0, po = 0;

   ps2_rx dut (
      .sys_clk    (sys_clk),
      .sys_res    (sys_res),
      .ps2clk     (ps2clk),
      .ps2dat     (ps2dat),
      .rd         (rd),
      .data       (data),
      .ready      (ready),
      .err_parity (err_parity),
      .err_frame  (err_frame),
      .overrun    (overrun)
   );

   always #83.333 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (err_parity) n_par++;
      if (err_frame) n_frm++;
      if (overrun) n_ovr++;
      if ((err_parity && pp) || (err_frame && pf) || (overrun && po)) n_wide++;
      pp = err_parity;
      pf = err_frame;
      po = overrun;
   end

   task automatic ps2_bit(input logic b);
      ps2clk = 1'b1;
      #20000 ps2dat = b;
      #20000 ps2clk = 1'b0;
      #40000;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic p,
                             input logic s, output int lat);
      logic [9:0] bits;
      bits = {p, b, 1'b0};
      for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
      ps2clk = 1'b1;
      #20000 ps2dat = s;
      #20000;
      ps2clk = 1'b0;
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge sys_clk);
         #1;
         if (ready && lat < 0) lat = k;
      end
      #30000 ps2clk = 1'b1;
      ps2dat = 1'b1;
      #40000;
   endtask

   task automatic rd_pulse();
      @(negedge sys_clk) rd = 1'b1;
      @(negedge sys_clk) rd = 1'b0;
   endtask

   task automatic test_reset();
      sys_res = 1'b1;
      repeat (5) @(posedge sys_clk);
      #1;
      nvec++; if (data !== 8'h00) begin nbad++; $display("FAIL reset_data: got %h want 00", data); end
      nvec++; if (ready !== 1'b0) begin nbad++; $display("FAIL reset_ready: got %b want 0", ready); end
      nvec++; if ({err_parity, err_frame, overrun} !== 3'b000) begin
         nbad++; $display("FAIL reset_pulses: got %b want 000", {err_parity, err_frame, overrun});
      end
      @(negedge sys_clk) sys_res = 1'b0;
      #100000;
   endtask

   task automatic test_good_frame();
      int lat, p0, f0, o0;
      p0 = n_par; f0 = n_frm; o0 = n_ovr;
      send_frame(8'h1C, 1'b0, 1'b1, lat);
      nvec++; if (lat < FL + 1 || lat > FL + 5) begin
         nbad++; $display("FAIL good_latency: got %0d cycles want %0d..%0d", lat, FL + 1, FL + 5);
      end
      nvec++; if (data !== 8'h1C) begin nbad++; $display("FAIL good_data: got %h want 1c", data); end
      nvec++; if (ready !== 1'b1) begin nbad++; $display("FAIL good_ready: got %b want 1", ready); end
      nvec++; if (n_par + n_frm + n_ovr - p0 - f0 - o0 != 0) begin
         nbad++; $display("FAIL good_pulses: got %0d want 0", n_par + n_frm + n_ovr - p0 - f0 - o0);
      end
      rd_pulse();
      nvec++; if (ready !== 1'b0) begin nbad++; $display("FAIL good_rd: got ready %b want 0", ready); end
   endtask

   task automatic test_parity_err();
      int lat, p0, f0;
      p0 = n_par; f0 = n_frm;
      send_frame(8'h1C, 1'b1, 1'b1, lat);
      nvec++; if (n_par - p0 != 1) begin nbad++; $display("FAIL par_pulse: got %0d want 1", n_par - p0); end
      nvec++; if (n_frm - f0 != 0) begin nbad++; $display("FAIL par_noframe: got %0d want 0", n_frm - f0); end
      nvec++; if (ready !== 1'b0) begin nbad++; $display("FAIL par_ready: got %b want 0", ready); end
   endtask

   task automatic test_stop_err();
      int lat, p0, f0;
      p0 = n_par; f0 = n_frm;
      send_frame(8'hF0, 1'b1, 1'b0, lat);
      nvec++; if (n_frm - f0 != 1) begin nbad++; $display("FAIL stop_pulse: got %0d want 1", n_frm - f0); end
      nvec++; if (n_par - p0 != 0) begin nbad++; $display("FAIL stop_nopar: got %0d want 0", n_par - p0); end
      nvec++; if (ready !== 1'b0) begin nbad++; $display("FAIL stop_ready: got %b want 0", ready); end
      p0 = n_par; f0 = n_frm;
      send_frame(8'hF0, 1'b0, 1'b0, lat);
      nvec++; if (n_par - p0 != 1 || n_frm - f0 != 0) begin
         nbad++; $display("FAIL both_prio: got par %0d frm %0d want 1 0", n_par - p0, n_frm - f0);
      end
   endtask

   task automatic test_timeout();
      int lat, f0, hit;
      logic [4:0] bits;
      bits = 5'b0_1010;
      f0 = n_frm;
      for (int i = 0; i < 4; i++) ps2_bit(bits[i]);
      ps2clk = 1'b1;
      #20000 ps2dat = bits[4];
      #20000 ps2clk = 1'b0;
      hit = -1;
      for (int k = 1; k <= 1500; k++) begin
         @(posedge sys_clk);
         #1;
         if (k == 240) ps2clk = 1'b1;
         if (err_frame && hit < 0) hit = k;
      end
      nvec++; if (hit < TO + FL + 1 || hit > TO + FL + 5) begin
         nbad++; $display("FAIL timeout_cyc: got %0d want %0d..%0d", hit, TO + FL + 1, TO + FL + 5);
      end
      #40000;
      nvec++; if (n_frm - f0 != 1) begin nbad++; $display("FAIL timeout_once: got %0d want 1", n_frm - f0); end
      f0 = n_frm;
      send_frame(8'h5A, 1'b1, 1'b1, lat);
      nvec++; if (data !== 8'h5A || ready !== 1'b1) begin
         nbad++; $display("FAIL timeout_next: got %h/%b want 5a/1", data, ready);
      end
      nvec++; if (n_frm - f0 != 0) begin nbad++; $display("FAIL timeout_clean: got %0d want 0", n_frm - f0); end
      rd_pulse();
   endtask

   task automatic test_back_to_back();
      int lat, o0;
      o0 = n_ovr;
      send_frame(8'h12, 1'b1, 1'b1, lat);
      send_frame(8'h34, 1'b0, 1'b1, lat);
`ifdef PS2_RX_FIFO_EN
      nvec++; if (n_ovr - o0 != 0) begin nbad++; $display("FAIL fifo_noovr: got %0d want 0", n_ovr - o0); end
      nvec++; if (data !== 8'h12) begin nbad++; $display("FAIL fifo_rd0: got %h want 12", data); end
      rd_pulse();
      nvec++; if (data !== 8'h34 || ready !== 1'b1) begin
         nbad++; $display("FAIL fifo_rd1: got %h/%b want 34/1", data, ready);
      end
      rd_pulse();
      nvec++; if (ready !== 1'b0) begin nbad++; $display("FAIL fifo_empty: got %b want 0", ready); end
      begin
         logic [7:0] vb [5];
         logic [4:0] vp;
         vb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
         vp = 5'b10100;
         for (int i = 0; i < 5; i++) begin
            send_frame(vb[i], vp[i], 1'b1, lat);
            if (i == 3) begin
               nvec++; if (n_ovr - o0 != 0) begin nbad++; $display("FAIL fifo_full_noovr: got %0d want 0", n_ovr - o0); end
            end
         end
         nvec++; if (n_ovr - o0 != 1) begin nbad++; $display("FAIL fifo_ovr: got %0d want 1", n_ovr - o0); end
         for (int i = 0; i < 4; i++) begin
            nvec++; if (data !== vb[i] || ready !== 1'b1) begin
               nbad++; $display("FAIL fifo_drain%0d: got %h/%b want %h/1", i, data, ready, vb[i]);
            end
            rd_pulse();
         end
      end
`else
      nvec++; if (data !== 8'h12) begin nbad++; $display("FAIL ovr_keep: got %h want 12", data); end
      nvec++; if (n_ovr - o0 != 1) begin nbad++; $display("FAIL ovr_pulse: got %0d want 1", n_ovr - o0); end
      rd_pulse();
`endif
      nvec++; if (ready !== 1'b0) begin nbad++; $display("FAIL b2b_drained: got %b want 0", ready); end
   endtask

   task automatic test_glitch_reset();
      int lat, p0, f0, o0;
      logic [5:0] bits;
      p0 = n_par; f0 = n_frm; o0 = n_ovr;
      @(negedge sys_clk);
      ps2dat = 1'b0;
      ps2clk = 1'b0;
      repeat (3) @(negedge sys_clk);
      ps2clk = 1'b1;
      #1000 ps2dat = 1'b1;
      #100000;
      send_frame(8'h5A, 1'b1, 1'b1, lat);
      nvec++; if (data !== 8'h5A || ready !== 1'b1) begin
         nbad++; $display("FAIL glitch_data: got %h/%b want 5a/1", data, ready);
      end
      nvec++; if (n_par + n_frm + n_ovr - p0 - f0 - o0 != 0) begin
         nbad++; $display("FAIL glitch_pulses: got %0d want 0", n_par + n_frm + n_ovr - p0 - f0 - o0);
      end
      bits = 6'b10_0110;
      for (int i = 0; i < 6; i++) ps2_bit(bits[i]);
      ps2clk = 1'b1;
      @(negedge sys_clk) sys_res = 1'b1;
      repeat (3) @(negedge sys_clk);
      sys_res = 1'b0;
      nvec++; if (ready !== 1'b0 || data !== 8'h00) begin
         nbad++; $display("FAIL rst_mid: got %h/%b want 00/0", data, ready);
      end
      #300000;
      nvec++; if (n_par + n_frm + n_ovr - p0 - f0 - o0 != 0) begin
         nbad++; $display("FAIL rst_silent: got %0d want 0", n_par + n_frm + n_ovr - p0 - f0 - o0);
      end
      send_frame(8'h34, 1'b0, 1'b1, lat);
      nvec++; if (data !== 8'h34 || ready !== 1'b1) begin
         nbad++; $display("FAIL rst_next: got %h/%b want 34/1", data, ready);
      end
      rd_pulse();
   endtask

   initial begin
      sys_res = 1'b1;
      ps2clk  = 1'b1;
      ps2dat  = 1'b1;
      rd      = 1'b0;
      test_reset();
      test_good_frame();
      test_parity_err();
      test_stop_err();
      test_timeout();
      test_back_to_back();
      test_glitch_reset();
      nvec++; if (n_wide != 0) begin nbad++; $display("FAIL pulse_width: got %0d long pulses want 0", n_wide); end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
